// File: rtl/frame_fetch_pkg.sv
// Shared definitions for the frame-fetch top level: scheduler state encoding
// and the default frame geometry expressed in 256-bit pixel-group beats.
package frame_fetch_pkg;

  localparam int FRAME_W_PX       = 640;
  localparam int FRAME_H_PX       = 480;
  localparam int BEAT_BITS        = 256;
  localparam int PIXEL_BITS       = 8;
  localparam int PX_PER_PG        = BEAT_BITS / PIXEL_BITS;
  localparam int FRAME_PG_NUM_DEF = (FRAME_W_PX * FRAME_H_PX) / PX_PER_PG;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_LOAD  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/frame_dispatch_scheduler_rr_arbiter.sv
// Combinational round-robin picker: returns the first requesting index at or
// after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);

  logic [W:0] w_sum;
  logic [W:0] w_idx;

  // Walk from the farthest offset back to ptr so the nearest request wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_sum     = '0;
    w_idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_sum = {1'b0, ptr} + (W + 1)'(i);
      w_idx = (w_sum >= (W + 1)'(N)) ? (w_sum - (W + 1)'(N)) : w_sum;
      if (req[w_idx[W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_idx[W-1:0];
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/frame_dispatch_scheduler.sv
// Grants idle image-processor lanes to the upstream frame source one frame at
// a time, monitors the frame's beats for framing errors and tracks lane busy.
module frame_dispatch_scheduler
  import frame_fetch_pkg::*;
#(
  parameter int IP_AMT       = 4,
  parameter int IP_ADDR_W    = (IP_AMT > 1) ? $clog2(IP_AMT) : 1,
  parameter int FRAME_PG_NUM = FRAME_PG_NUM_DEF,
  parameter int PG_CNT_W     = $clog2(FRAME_PG_NUM + 1)
) (
  input  logic                 s_aclk,
  input  logic                 s_aresetn,
  input  logic                 dest_req_i,
  output logic                 dest_gnt_o,
  output logic [IP_ADDR_W-1:0] dest_id_o,
  input  logic [IP_ADDR_W-1:0] s_tdest_i,
  input  logic                 s_tlast_i,
  input  logic                 s_tvalid_i,
  input  logic                 s_tready_i,
  input  logic [IP_AMT-1:0]    frame_complete_i,
  output logic [IP_AMT-1:0]    ip_busy_o,
  output logic                 loading_o,
  output logic                 err_short_o,
  output logic                 err_long_o,
  output logic                 err_dest_o,
  input  logic                 err_clr_i
);

  sched_state_e         r_state;
  sched_state_e         w_state_nxt;
  logic                 r_gnt;
  logic                 r_loading;
  logic [IP_ADDR_W-1:0] r_dest_id;
  logic [IP_ADDR_W-1:0] r_last_grant;
  logic [IP_AMT-1:0]    r_busy;
  logic [PG_CNT_W-1:0]  r_cnt;
  logic                 r_err_short;
  logic                 r_err_long;
  logic                 r_err_dest;

  logic [IP_ADDR_W-1:0] w_ptr;
  logic                 w_arb_valid;
  logic [IP_ADDR_W-1:0] w_arb_idx;
  logic [IP_AMT-1:0]    w_busy_set;
  logic                 w_take;
  logic                 w_beat;
  logic                 w_last_beat;
  logic                 w_end;
  logic                 w_set_short;
  logic                 w_set_long;
  logic                 w_set_dest;

  rr_arbiter #(
    .N (IP_AMT),
    .W (IP_ADDR_W)
  ) u_arb (
    .req       (~r_busy),
    .ptr       (w_ptr),
    .gnt_valid (w_arb_valid),
    .gnt_idx   (w_arb_idx)
  );

  assign w_busy_set = w_take ? (IP_AMT'(1) << w_arb_idx) : '0;

  // Search pointer starts one past the most recently granted lane
  always_comb begin
    if (r_last_grant == IP_ADDR_W'(IP_AMT - 1)) begin
      w_ptr = '0;
    end else begin
      w_ptr = r_last_grant + IP_ADDR_W'(1);
    end
  end

  // Scheduler state register
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus grant / framing-error strobes
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_end       = 1'b0;
    w_set_short = 1'b0;
    w_set_long  = 1'b0;
    w_set_dest  = 1'b0;
    w_beat      = s_tvalid_i & s_tready_i;
    w_last_beat = (r_cnt == PG_CNT_W'(FRAME_PG_NUM - 1));
    case (r_state)
      ST_IDLE: begin
        if (dest_req_i && w_arb_valid) begin
          w_take      = 1'b1;
          w_state_nxt = ST_GRANT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_beat) begin
          w_set_dest = (s_tdest_i != r_dest_id);
          if (w_last_beat) begin
            w_set_long = ~s_tlast_i;
            w_end      = 1'b1;
          end else if (s_tlast_i) begin
            w_set_short = 1'b1;
            w_end       = 1'b1;
          end else begin
            w_end = 1'b0;
          end
        end else begin
          w_end = 1'b0;
        end
        w_state_nxt = w_end ? ST_IDLE : ST_LOAD;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered outputs, lane bookkeeping, beat counter and sticky errors
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_gnt        <= 1'b0;
      r_loading    <= 1'b0;
      r_dest_id    <= '0;
      r_last_grant <= IP_ADDR_W'(IP_AMT - 1);
      r_busy       <= '0;
      r_cnt        <= '0;
      r_err_short  <= 1'b0;
      r_err_long   <= 1'b0;
      r_err_dest   <= 1'b0;
    end else begin
      r_gnt     <= (w_state_nxt == ST_GRANT);
      r_loading <= (w_state_nxt == ST_LOAD);
      r_busy    <= (r_busy & ~frame_complete_i) | w_busy_set;
      if (w_take) begin
        r_dest_id    <= w_arb_idx;
        r_last_grant <= w_arb_idx;
      end
      // Counter is parked at zero outside a load so stray beats never count
      if ((r_state == ST_GRANT) || w_end) begin
        r_cnt <= '0;
      end else if ((r_state == ST_LOAD) && w_beat) begin
        r_cnt <= r_cnt + PG_CNT_W'(1);
      end
      r_err_short <= w_set_short | (r_err_short & ~err_clr_i);
      r_err_long  <= w_set_long  | (r_err_long  & ~err_clr_i);
      r_err_dest  <= w_set_dest  | (r_err_dest  & ~err_clr_i);
    end
  end

  assign dest_gnt_o  = r_gnt;
  assign dest_id_o   = r_dest_id;
  assign ip_busy_o   = r_busy;
  assign loading_o   = r_loading;
  assign err_short_o = r_err_short;
  assign err_long_o  = r_err_long;
  assign err_dest_o  = r_err_dest;

endmodule

// File: tb/tb_frame_dispatch_scheduler.sv
// Bench for frame_dispatch_scheduler (4 lanes, 4-beat frames): directed vector
// table, corner-case sequences and random traffic against a behavioural model.
module tb_frame_dispatch_scheduler;

  localparam int NL  = 4;
  localparam int NPG = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dest_req_i = 1'b0;
  logic       dest_gnt_o;
  logic [1:0] dest_id_o;
  logic [1:0] s_tdest_i = 2'd0;
  logic       s_tlast_i = 1'b0;
  logic       s_tvalid_i = 1'b0;
  logic       s_tready_i = 1'b0;
  logic [3:0] frame_complete_i = 4'd0;
  logic [3:0] ip_busy_o;
  logic       loading_o;
  logic       err_short_o, err_long_o, err_dest_o;
  logic       err_clr_i = 1'b0;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = waiting, 1 = grant cycle, 2 = streaming
  int         m_phase, m_last, m_id, m_beats;
  logic [3:0] m_busy;
  logic       m_es, m_el, m_ed;

  always #5 clk = ~clk;

  frame_dispatch_scheduler #(
    .IP_AMT(NL), .IP_ADDR_W(2), .FRAME_PG_NUM(NPG), .PG_CNT_W(3)
  ) dut (
    .s_aclk(clk), .s_aresetn(rst_n), .dest_req_i(dest_req_i), .dest_gnt_o(dest_gnt_o),
    .dest_id_o(dest_id_o), .s_tdest_i(s_tdest_i), .s_tlast_i(s_tlast_i),
    .s_tvalid_i(s_tvalid_i), .s_tready_i(s_tready_i), .frame_complete_i(frame_complete_i),
    .ip_busy_o(ip_busy_o), .loading_o(loading_o), .err_short_o(err_short_o),
    .err_long_o(err_long_o), .err_dest_o(err_dest_o), .err_clr_i(err_clr_i)
  );

  typedef struct {
    logic        req;
    logic [1:0]  tdest;
    logic        beat;
    logic        tlast;
    logic [3:0]  fc;
    logic        clr;
    logic [10:0] exp; // {gnt, id[1:0], busy[3:0], loading, short, long, dest}
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] act_vec();
    return {dest_gnt_o, dest_id_o, ip_busy_o, loading_o, err_short_o, err_long_o, err_dest_o};
  endfunction

  function automatic logic [10:0] exp_vec();
    return {(m_phase == 1), 2'(m_id), m_busy, (m_phase == 2), m_es, m_el, m_ed};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_last = NL - 1; m_id = 0; m_beats = 0;
    m_busy = 4'd0; m_es = 1'b0; m_el = 1'b0; m_ed = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] nb;
    int c;
    logic ss, sl, sd;
    ss = 1'b0; sl = 1'b0; sd = 1'b0; c = 0;
    nb = m_busy & ~frame_complete_i;
    if (m_phase == 0) begin
      if (dest_req_i && (m_busy != 4'hF)) begin
        for (int i = 1; i <= NL; i++) begin
          c = (m_last + i) % NL;
          if (!m_busy[c]) break;
        end
        m_id = c; m_last = c; nb[c] = 1'b1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_beats = 0; m_phase = 2;
    end else if (s_tvalid_i && s_tready_i) begin
      if (s_tdest_i != 2'(m_id)) sd = 1'b1;
      m_beats++;
      if (m_beats == NPG) begin
        if (!s_tlast_i) sl = 1'b1;
        m_phase = 0;
      end else if (s_tlast_i) begin
        ss = 1'b1;
        m_phase = 0;
      end
    end
    m_busy = nb;
    m_es = ss | (m_es & ~err_clr_i);
    m_el = sl | (m_el & ~err_clr_i);
    m_ed = sd | (m_ed & ~err_clr_i);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model", {21'd0, act_vec()}, {21'd0, exp_vec()});
  endtask

  task automatic clear_inputs();
    dest_req_i = 1'b0; s_tdest_i = 2'd0; s_tlast_i = 1'b0; s_tvalid_i = 1'b0;
    s_tready_i = 1'b0; frame_complete_i = 4'd0; err_clr_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check("reset_vals", {21'd0, act_vec()}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic get_grant(output int id);
    id = -1;
    dest_req_i = 1'b1;
    for (int n = 0; n < 12 && id < 0; n++) begin
      tick();
      if (dest_gnt_o === 1'b1) id = int'(dest_id_o);
    end
    dest_req_i = 1'b0;
    check("grant_seen", {31'd0, (id >= 0)}, 32'd1);
    tick();
  endtask

  task automatic send_frame(input int dest, input int nbeats, input int tlast_at, input int bad_at);
    for (int b = 0; b < nbeats; b++) begin
      s_tvalid_i = 1'b1; s_tready_i = 1'b1;
      s_tdest_i  = (b == bad_at) ? 2'(dest + 2) : 2'(dest);
      s_tlast_i  = (b == tlast_at);
      tick();
    end
    clear_inputs();
  endtask

  task automatic fc_pulse(input logic [3:0] m);
    frame_complete_i = m;
    tick();
    frame_complete_i = 4'd0;
  endtask

  initial begin
    int id;
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0, 11'b1_00_0001_0_000};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0, 11'b0_00_0001_1_000};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 1'b0, 4'h0, 1'b0, 11'b0_00_0001_1_000};
    tbl[3]  = '{1'b0, 2'd0, 1'b1, 1'b0, 4'h0, 1'b0, 11'b0_00_0001_1_000};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 1'b0, 4'h0, 1'b0, 11'b0_00_0001_1_000};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 1'b1, 4'h0, 1'b0, 11'b0_00_0001_0_000};
    tbl[6]  = '{1'b1, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0, 11'b1_01_0011_0_000};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0, 11'b0_01_0011_1_000};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 1'b1, 4'h0, 1'b0, 11'b0_01_0011_0_100};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1, 11'b0_01_0011_0_000};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h1, 1'b0, 11'b0_01_0010_0_000};
    tbl[11] = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0, 11'b0_01_0010_0_000};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      dest_req_i = tbl[i].req; s_tdest_i = tbl[i].tdest;
      s_tvalid_i = tbl[i].beat; s_tready_i = tbl[i].beat; s_tlast_i = tbl[i].tlast;
      frame_complete_i = tbl[i].fc; err_clr_i = tbl[i].clr;
      tick();
      check($sformatf("vec%0d", i), {21'd0, act_vec()}, {21'd0, tbl[i].exp});
    end
    clear_inputs();

    // Round-robin fill of all lanes, then a blocked fifth request
    do_reset();
    for (int f = 0; f < NL; f++) begin
      get_grant(id);
      check($sformatf("rr_id%0d", f), id, f);
      send_frame(id, NPG, NPG - 1, -1);
    end
    check("busy_full", {28'd0, ip_busy_o}, 32'hF);
    dest_req_i = 1'b1;
    repeat (4) begin
      tick();
      check("no_grant_full", {31'd0, dest_gnt_o}, 32'd0);
    end
    fc_pulse(4'b0100);
    check("busy_after_fc", {28'd0, ip_busy_o}, 32'hB);
    tick();
    check("regrant_gnt", {31'd0, dest_gnt_o}, 32'd1);
    check("regrant_id", {30'd0, dest_id_o}, 32'd2);
    dest_req_i = 1'b0;
    tick();
    send_frame(2, NPG, NPG - 1, -1);

    // Short frame, immediate regrant, error clear
    fc_pulse(4'b0011);
    get_grant(id);
    check("short_lane", id, 0);
    send_frame(0, 2, 1, -1);
    check("short_err", {31'd0, err_short_o}, 32'd1);
    check("short_unload", {31'd0, loading_o}, 32'd0);
    dest_req_i = 1'b1;
    tick();
    check("fast_regrant", {31'd0, dest_gnt_o}, 32'd1);
    check("fast_regrant_id", {30'd0, dest_id_o}, 32'd1);
    dest_req_i = 1'b0;
    tick();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("short_clr", {31'd0, err_short_o}, 32'd0);

    // Long frame on lane 1
    send_frame(1, NPG, -1, -1);
    check("long_err", {31'd0, err_long_o}, 32'd1);
    check("long_unload", {31'd0, loading_o}, 32'd0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;

    // Wrong TDEST on one beat of an otherwise clean frame
    fc_pulse(4'b0010);
    get_grant(id);
    check("dest_lane", id, 1);
    send_frame(1, NPG, NPG - 1, 1);
    check("dest_err", {29'd0, err_short_o, err_long_o, err_dest_o}, 32'd1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;

    // Spurious completion and stray beats while idle
    fc_pulse(4'b1000);
    check("busy_fc3", {28'd0, ip_busy_o}, 32'h7);
    fc_pulse(4'b1000);
    check("spurious_fc", {21'd0, act_vec()}, {21'd0, 11'b0_01_0111_0_000});
    s_tvalid_i = 1'b1; s_tready_i = 1'b1; s_tlast_i = 1'b1;
    repeat (3) tick();
    clear_inputs();
    check("idle_beats", {28'd0, loading_o, err_short_o, err_long_o, err_dest_o}, 32'd0);
    get_grant(id);
    check("after_stray_lane", id, 3);
    send_frame(3, NPG, NPG - 1, -1);
    check("after_stray_errs", {29'd0, err_short_o, err_long_o, err_dest_o}, 32'd0);

    // Reset in the middle of a load
    fc_pulse(4'b1000);
    get_grant(id);
    send_frame(3, 2, -1, -1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async", {21'd0, act_vec()}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_held", {21'd0, act_vec()}, 32'd0);
    #2;
    rst_n = 1'b1;
    get_grant(id);
    check("post_rst_lane", id, 0);
    clear_inputs();

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      dest_req_i       = ($urandom_range(0, 1) == 1);
      s_tvalid_i       = ($urandom_range(0, 9) < 7);
      s_tready_i       = ($urandom_range(0, 9) < 8);
      s_tdest_i        = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_id);
      s_tlast_i        = (m_beats == NPG - 1) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 7) == 0);
      frame_complete_i = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
      err_clr_i        = ($urandom_range(0, 19) == 0);
      tick();
    end
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
